fetch_exec_sequencer: RTL and testbench
=======================================

// Module: fetch_exec_sequencer
// PURPOSE
//  Multi-cycle instruction sequencer for the single-bus CPU datapath. Owns the PC, IR and link register.
//  Runs the fetch/decode/execute state machine with a req/ack memory handshake and drives the datapath
//  control word (IL, MB, FS, MD, RW, MM, MW) each cycle. Sits between the instruction/data memory port
//  and the register file/ALU.
// PARAMETERS
//  PC_W     8   PC, link and memory address width; all PC arithmetic is modulo 2^PC_W
//  INSTR_W  16  instruction width; opcode = instr[INSTR_W-1 -: 4], offset = instr[7:0] (signed)
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        asynchronous, active-high reset
//  run       in   1        high: fetch new instructions; low: finish current instr, then IDLE
//  mem_rdata in   INSTR_W  memory read data, valid when mem_ack=1
//  mem_ack   in   1        memory completion for the current mem_req (may arrive same cycle)
//  z         in   1        ALU zero flag from datapath, sampled in EXEC
//  mem_req   out  1        memory request, held until mem_ack
//  mem_we    out  1        write qualifier for mem_req (store)
//  mem_addr  out  PC_W     pc when mm=1, else instr[7:0] zero-extended (direct address)
//  pc        out  PC_W     current program counter
//  ir        out  INSTR_W  instruction register
//  il        out  1        IR load strobe (fetch ack cycle)
//  mb        out  1        B-mux select constant (LDI)
//  fs        out  4        ALU function = ir opcode
//  md        out  1        writeback selects memory data (LD)
//  rw        out  1        register-file write strobe, one cycle per instr max
//  mm        out  1        memory address select: 1=pc, 0=data address
//  mw        out  1        memory write strobe (= mem_we)
//  busy      out  1        high whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=0, ir=0, link=0; all strobes 0, mm=0. Outputs are Moore/Mealy on
//    registered state+ir; mem_req drops the instant rst rises, even mid-handshake; no PC update.
//  States: IDLE -> FETCH (run=1). FETCH: mem_req=1, mm=1; on mem_ack: ir<=mem_rdata, il=1 -> DECODE.
//    DECODE (1 cycle): opcodes 1001/1010 -> MEM, all others -> EXEC.
//    EXEC (1 cycle): perform op, update pc -> FETCH if run else IDLE.
//    MEM: mem_req=1, mm=0, mem_we=mw=(op==1010); on ack: LD sets md=1, rw=1; pc<=pc+1 -> FETCH/IDLE.
//  Opcodes (EXEC unless noted), next pc:
//    0xxx ALU: rw=1, fs=op, pc+1    1000 LDI: mb=1, rw=1, pc+1    1001 LD / 1010 ST: via MEM
//    1011 BZ: z ? pc+sext(off) : pc+1    1100 BNZ: z ? pc+1 : pc+sext(off)
//    1101 JAL: link<=pc+1, pc<=pc+sext(off)    1110 JMP: pc+sext(off)    1111 RET: pc<=link
//  Latency: zero-wait memory -> every instruction takes exactly 3 cycles; each ack wait adds 1.
//  Wrap: pc+1 at 2^PC_W-1 -> 0; branch target truncated to PC_W bits (e.g. 0x02+0xFC = 0xFE).
//  mem_ack outside FETCH/MEM ignored. mem_addr stable while mem_req=1.
//  run falling mid-instr: instr completes with normal pc update, then IDLE; run is sampled only on
//    the EXEC or MEM-ack cycle and in IDLE.
//  JAL whose target overwrites link before a RET: single-level link, newest JAL wins.
// STRUCTURE
//  Shared include seq_defs.vh: state encodings (IDLE, FETCH, DECODE, EXEC, MEM, 3 bits), opcode
//    constants (OP_LDI..OP_RET), PS encodings (HOLD=00, INC=01, BR=10, RET=11).
//  One sub-module: pc_unit (pc and link registers, next-pc mux on PS, sign-extend adder).
//  Controller FSM and control-word decode stay in this module.
// TESTING
//  1 Reset mid-FETCH with mem_req=1 -> mem_req=0 immediately; pc=0, state IDLE after release.
//  2 Zero-wait memory, ALU op 0x3xxx at pc=0x05 -> il in cycle 1, rw=1 and fs=3 in cycle 3,
//    pc=0x06, next FETCH in cycle 4.
//  3 LD 0x9x40, mem_ack delayed 2 cycles in MEM -> mem_addr=0x40, mm=0, rw=md=1 only on ack
//    cycle, pc+1.
//  4 BZ off=0xFC at pc=0x02, z=1 -> pc=0xFE; same with z=0 -> pc=0x03; BNZ inverse.
//  5 JAL off=0x10 at pc=0x20 then RET at 0x30 -> pc 0x30, link 0x21, then pc=0x21.
//  6 pc=0xFF ALU op -> pc wraps to 0x00; run dropped during DECODE -> instr completes, busy=0 next.

Source files
------------

// File: rtl/fetch_exec_sequencer_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer: state and PC-select
// encodings, opcode constants and the memory-op decode helper.
package fetch_exec_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_BR   = 2'b10,
    PS_RET  = 2'b11
  } ps_t;

  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_LD  = 4'b1001;
  localparam logic [3:0] OP_ST  = 4'b1010;
  localparam logic [3:0] OP_BZ  = 4'b1011;
  localparam logic [3:0] OP_BNZ = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1101;
  localparam logic [3:0] OP_JMP = 4'b1110;
  localparam logic [3:0] OP_RET = 4'b1111;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/fetch_exec_sequencer_pc_unit.sv
// Program counter and single-level link register with next-PC select
// (hold / increment / sign-extended relative branch / return).
module pc_unit
  import fetch_exec_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  ps_t             ps,
  input  logic            link_we,
  input  logic [7:0]      off,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] link
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_br;
  logic [PC_W-1:0] pc_nxt;

  // Both sums wrap modulo 2^PC_W; the offset is sign-extended before the add.
  assign pc_inc = pc + PC_W'(1);
  assign pc_br  = pc + PC_W'($signed(off));

  always_comb begin
    pc_nxt = pc;
    unique case (ps)
      PS_HOLD: pc_nxt = pc;
      PS_INC:  pc_nxt = pc_inc;
      PS_BR:   pc_nxt = pc_br;
      PS_RET:  pc_nxt = link;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= '0;
      link <= '0;
    end else begin
      pc <= pc_nxt;
      if (link_we) link <= pc_inc;
    end
  end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns IR, drives the memory
// handshake and the datapath control word; PC/link live in pc_unit.
module fetch_exec_sequencer
  import fetch_exec_sequencer_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  input  logic               z,
  output logic               mem_req,
  output logic               mem_we,
  output logic [PC_W-1:0]    mem_addr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic               il,
  output logic               mb,
  output logic [3:0]         fs,
  output logic               md,
  output logic               rw,
  output logic               mm,
  output logic               mw,
  output logic               busy
);

  state_t          state, state_nxt;
  ps_t             ps;
  logic            link_we;
  logic [3:0]      op;
  logic [PC_W-1:0] link;

  assign op = ir[INSTR_W-1 -: 4];

  pc_unit #(.PC_W(PC_W)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .ps      (ps),
    .link_we (link_we),
    .off     (ir[7:0]),
    .pc      (pc),
    .link    (link)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (il) ir <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    ps        = PS_HOLD;
    link_we   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    il        = 1'b0;
    mb        = 1'b0;
    md        = 1'b0;
    rw        = 1'b0;
    mm        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        mm      = 1'b1;
        if (mem_ack) begin
          il        = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_nxt = is_mem_op(op) ? ST_MEM : ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = run ? ST_FETCH : ST_IDLE;
        case (op)
          OP_LDI: begin
            mb = 1'b1;
            rw = 1'b1;
            ps = PS_INC;
          end
          OP_BZ:  ps = z ? PS_BR : PS_INC;
          OP_BNZ: ps = z ? PS_INC : PS_BR;
          OP_JAL: begin
            link_we = 1'b1;
            ps      = PS_BR;
          end
          OP_JMP: ps = PS_BR;
          OP_RET: ps = PS_RET;
          default: begin
            // LD/ST never reach EXEC; only the 0xxx ALU group lands here.
            if (!op[3]) begin
              rw = 1'b1;
              ps = PS_INC;
            end
          end
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_ST);
        if (mem_ack) begin
          md        = (op == OP_LD);
          rw        = (op == OP_LD);
          ps        = PS_INC;
          state_nxt = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign fs       = op;
  assign mw       = mem_we;
  assign busy     = (state != ST_IDLE);
  assign mem_addr = mm ? pc : PC_W'(ir[7:0]);

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed and randomized bench for fetch_exec_sequencer against an
// instruction-level reference model of PC/link behaviour and control timing.
module tb_fetch_exec_sequencer;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ack;
  logic               z;
  logic               mem_req, mem_we, il, mb, md, rw, mm, mw, busy;
  logic [PC_W-1:0]    mem_addr, pc;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         fs;

  int tests = 0;
  int fails = 0;

  logic [7:0] pc_m;
  logic [7:0] link_m;
  logic       idle_m;

  fetch_exec_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .z         (z),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .pc        (pc),
    .ir        (ir),
    .il        (il),
    .mb        (mb),
    .fs        (fs),
    .md        (md),
    .rw        (rw),
    .mm        (mm),
    .mw        (mw),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nextcyc;
    @(posedge clk);
    #1;
  endtask

  // One IDLE cycle with run=1 so the next edge enters FETCH.
  task automatic start;
    run = 1'b1;
    mem_ack = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_req", mem_req, 0);
    nextcyc;
    idle_m = 1'b0;
  endtask

  // Runs one instruction from FETCH to completion, checking every cycle.
  task automatic do_instr(input logic [15:0] instr, input int fd, input int mdl,
                          input logic zin, input logic run_after);
    logic [3:0] op;
    logic [7:0] off;
    logic [7:0] npc;
    logic       ld, st, wr;
    if (idle_m) start();
    op  = instr[15:12];
    off = instr[7:0];
    ld  = (op == 4'b1001);
    st  = (op == 4'b1010);
    for (int i = 0; i < fd; i++) begin
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      #1;
      chk("fetch_req", mem_req, 1);
      chk("fetch_mm", mm, 1);
      chk("fetch_addr", mem_addr, pc_m);
      chk("fetch_il_wait", il, 0);
      nextcyc;
    end
    mem_ack = 1'b1;
    mem_rdata = instr;
    #1;
    chk("fetch_il", il, 1);
    chk("fetch_req_ack", mem_req, 1);
    chk("fetch_addr_ack", mem_addr, pc_m);
    nextcyc;
    mem_ack = 1'($urandom);
    mem_rdata = 16'($urandom);
    run = run_after;
    #1;
    chk("dec_ir", ir, instr);
    chk("dec_req", mem_req, 0);
    chk("dec_rw", rw, 0);
    chk("dec_il", il, 0);
    chk("dec_busy", busy, 1);
    nextcyc;
    npc = pc_m + 8'd1;
    if (ld || st) begin
      for (int i = 0; i < mdl; i++) begin
        mem_ack = 1'b0;
        #1;
        chk("mem_req", mem_req, 1);
        chk("mem_mm", mm, 0);
        chk("mem_addr", mem_addr, off);
        chk("mem_we", mem_we, st);
        chk("mem_mw", mw, st);
        chk("mem_rw_wait", rw, 0);
        chk("mem_md_wait", md, 0);
        nextcyc;
      end
      mem_ack = 1'b1;
      #1;
      chk("mem_req_ack", mem_req, 1);
      chk("mem_addr_ack", mem_addr, off);
      chk("mem_rw_ack", rw, ld);
      chk("mem_md_ack", md, ld);
      chk("mem_we_ack", mem_we, st);
      nextcyc;
    end else begin
      mem_ack = 1'($urandom);
      z = zin;
      wr = (op[3] == 1'b0) || (op == 4'b1000);
      #1;
      chk("ex_req", mem_req, 0);
      chk("ex_rw", rw, wr);
      chk("ex_mb", mb, op == 4'b1000);
      chk("ex_fs", fs, op);
      chk("ex_md", md, 0);
      case (op)
        4'b1011: npc = zin ? pc_m + off : pc_m + 8'd1;
        4'b1100: npc = zin ? pc_m + 8'd1 : pc_m + off;
        4'b1101: begin link_m = pc_m + 8'd1; npc = pc_m + off; end
        4'b1110: npc = pc_m + off;
        4'b1111: npc = link_m;
        default: npc = pc_m + 8'd1;
      endcase
      nextcyc;
    end
    mem_ack = 1'b0;
    pc_m = npc;
    #1;
    chk("pc", pc, pc_m);
    chk("busy_after", busy, run_after);
    chk("req_after", mem_req, run_after);
    idle_m = !run_after;
  endtask

  task automatic jump_to(input logic [7:0] t);
    logic [7:0] d;
    d = t - pc_m;
    do_instr({8'hE0, d}, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0; z = 1'b0;
    pc_m = 8'h00; link_m = 8'h00; idle_m = 1'b1;
    nextcyc;
    nextcyc;
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {il, rw, md, mw, mb, mm}, 0);
    rst = 1'b0;
    start();
    #1;
    chk("t1_req_before", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("t1_req_drop", mem_req, 0);
    chk("t1_busy_drop", busy, 0);
    nextcyc;
    rst = 1'b0;
    #1;
    chk("t1_pc", pc, 0);
    idle_m = 1'b1;

    jump_to(8'h05);
    do_instr(16'h3123, 0, 0, 1'b0, 1'b1);   // ALU at 0x05 -> 0x06
    do_instr(16'h9A40, 0, 2, 1'b0, 1'b1);   // LD with two wait cycles
    do_instr(16'hA055, 1, 1, 1'b0, 1'b1);   // ST
    jump_to(8'h02);
    do_instr(16'hB0FC, 0, 0, 1'b1, 1'b1);   // BZ taken -> 0xFE
    jump_to(8'h02);
    do_instr(16'hB0FC, 0, 0, 1'b0, 1'b1);   // BZ not taken -> 0x03
    jump_to(8'h02);
    do_instr(16'hC0FC, 0, 0, 1'b0, 1'b1);   // BNZ taken -> 0xFE
    jump_to(8'h02);
    do_instr(16'hC0FC, 0, 0, 1'b1, 1'b1);   // BNZ not taken -> 0x03
    jump_to(8'h20);
    do_instr(16'hD010, 0, 0, 1'b0, 1'b1);   // JAL -> 0x30, link 0x21
    do_instr(16'hF000, 0, 0, 1'b0, 1'b1);   // RET -> 0x21
    do_instr(16'hD005, 0, 0, 1'b0, 1'b1);   // JAL again: newest link wins
    do_instr(16'hF000, 2, 0, 1'b0, 1'b1);
    do_instr(16'h8077, 0, 0, 1'b0, 1'b1);   // LDI
    jump_to(8'hFF);
    do_instr(16'h1234, 0, 0, 1'b0, 1'b0);   // wrap to 0x00, run dropped in DECODE
    do_instr(16'h5000, 1, 0, 1'b1, 1'b1);

    for (int n = 0; n < 200; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      do_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               1'($urandom), ($urandom_range(0, 7) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
